// File: rtl/range_report_pkg.sv
// range_report_pkg: shared state encoding and frame header constants for the range report transmitter.
package range_report_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [7:0] HDR_OK  = 8'h52;
    localparam logic [7:0] HDR_ERR = 8'h45;
    function automatic logic [7:0] header(input logic err);
        return err ? HDR_ERR : HDR_OK;
    endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 serializer; done pulses in the last stop-bit cycle so a new start continues with no gap.
module uart_byte_tx
    import range_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic tx_q, tx_d, last, load;
    assign last = cnt_q == LAST;
    assign done = state_q == STOP && last;
    // A start is honoured while idle or exactly when the stop bit ends.
    assign load = start && (state_q == IDLE || done);
    assign tx   = tx_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        if (load) begin
            state_d = START;
            cnt_d   = '0;
            bit_d   = '0;
            sh_d    = data;
            tx_d    = 1'b0;
        end else if (last) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    tx_d    = sh_q[0];
                end
                DATA: begin
                    bit_d   = bit_q + 1'b1;
                    sh_d    = sh_q >> 1;
                    state_d = bit_q == 3'd7 ? STOP : DATA;
                    tx_d    = bit_q == 3'd7 ? 1'b1 : sh_q[1];
                end
                STOP: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: rtl/range_report_tx.sv
// range_report_tx: captures a range/error result and sends it as a header byte plus range byte over UART.
module range_report_tx
    import range_report_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] range,
    input  logic             error,
    input  logic             result_valid,
    output logic             tx,
    output logic             busy,
    output logic             overrun
);
    logic [WIDTH-1:0] range_q, range_d;
    logic busy_q, busy_d, byte_q, byte_d, ovr_q, ovr_d;
    logic accept, start, done;
    logic [7:0] data;
    assign accept = result_valid && !busy_q;
    assign start  = accept || (done && !byte_q);
    // Header leaves on the accept edge itself, so it comes straight from the strobed inputs.
    assign data    = busy_q ? 8'(range_q) : header(error);
    assign busy    = busy_q;
    assign overrun = ovr_q;
    always_comb begin
        range_d = accept ? range : range_q;
        busy_d  = accept ? 1'b1 : (done && byte_q) ? 1'b0 : busy_q;
        byte_d  = done ? !byte_q : byte_q;
        ovr_d   = ovr_q || (result_valid && busy_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_q <= '0;
            busy_q  <= 1'b0;
            byte_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            range_q <= range_d;
            busy_q  <= busy_d;
            byte_q  <= byte_d;
            ovr_q   <= ovr_d;
        end
    end
    uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .data (data),
        .tx   (tx),
        .done (done)
    );
endmodule

// File: tb/tb_range_report_tx.sv
// tb_range_report_tx: decodes the UART line of an 8-bit and a 5-bit instance against an expected-frame model.
module tb_range_report_tx;
    localparam int C = 4;
    localparam int FRAME = 20 * C;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] rng = '0;
    logic err = 1'b0;
    logic rv = 1'b0;
    logic tx, busy, overrun, tx5, busy5, overrun5;
    int tests = 0;
    int fails = 0;
    logic ovr_exp = 1'b0;
    always #5 clk = ~clk;
    range_report_tx #(.WIDTH(8), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n), .range(rng), .error(err), .result_valid(rv),
        .tx(tx), .busy(busy), .overrun(overrun)
    );
    range_report_tx #(.WIDTH(5), .CLKS_PER_BIT(C)) dut5 (
        .clk(clk), .rst_n(rst_n), .range(rng[4:0]), .error(err), .result_valid(rv),
        .tx(tx5), .busy(busy5), .overrun(overrun5)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Strobe one result, optionally strobe a second one drop_at cycles into the frame, then decode the line.
    task automatic frame(input string tag, input logic [7:0] r, input logic e, input int drop_at,
                         input logic [7:0] dr, input bit sel);
        logic line [30*C];
        logic [19:0] v;
        int bcnt;
        bit timing_ok, busy_ok;
        @(negedge clk);
        rng = r; err = e; rv = 1'b1;
        @(negedge clk);
        rv = 1'b0;
        bcnt = 0; busy_ok = 1'b1; timing_ok = 1'b1;
        for (int k = 0; k < 30 * C; k++) begin
            line[k] = sel ? tx5 : tx;
            if (sel ? busy5 : busy) bcnt++;
            if ((sel ? busy5 : busy) !== (k < FRAME)) busy_ok = 1'b0;
            if (k == drop_at) begin
                rng = dr; err = ~e; rv = 1'b1;
            end
            @(negedge clk);
            rv = 1'b0;
        end
        for (int j = 0; j < 20; j++) begin
            v[j] = line[j * C];
            for (int m = 1; m < C; m++) if (line[j * C + m] !== line[j * C]) timing_ok = 1'b0;
        end
        for (int k = FRAME; k < 30 * C; k++) if (line[k] !== 1'b1) timing_ok = 1'b0;
        if (v[0] !== 1'b0 || v[9] !== 1'b1 || v[10] !== 1'b0 || v[19] !== 1'b1) timing_ok = 1'b0;
        if (drop_at >= 0 && drop_at < FRAME) ovr_exp = 1'b1;
        check({tag, "_hdr"}, v[8:1], e ? 8'h45 : 8'h52);
        check({tag, "_range"}, v[18:11], sel ? (r & 8'h1F) : r);
        check({tag, "_busy_cycles"}, bcnt, FRAME);
        check({tag, "_busy_shape"}, busy_ok, 1);
        check({tag, "_bit_timing"}, timing_ok, 1);
        check({tag, "_overrun"}, sel ? overrun5 : overrun, ovr_exp);
    endtask
    initial begin
        bit stable;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        stable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) stable = 1'b0;
        end
        check("idle_after_reset", stable, 1);
        frame("normal", 8'h3C, 1'b0, -1, 8'h00, 1'b0);
        frame("error", 8'h00, 1'b1, -1, 8'h00, 1'b0);
        frame("overrun", 8'h11, 1'b0, 10, 8'h22, 1'b0);
        frame("after_ovr", 8'h5A, 1'b0, -1, 8'h00, 1'b0);
        frame("drop_last_stop", 8'hC3, 1'b1, FRAME - 1, 8'h7E, 1'b0);
        frame("narrow", 8'h1F, 1'b0, -1, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] r;
            logic e;
            int d;
            r = 8'($urandom);
            e = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 1) ? int'($urandom_range(0, FRAME - 1)) : -1;
            frame("rand", r, e, d, 8'($urandom), 1'b0);
        end
        @(negedge clk);
        rng = 8'h00; err = 1'b0; rv = 1'b1;
        @(negedge clk);
        rv = 1'b0;
        repeat (14 * C + 1) @(negedge clk);
        check("mid_tx_before", tx, 0);
        check("mid_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        ovr_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_idle_tx", tx, 1);
        frame("post_reset", 8'hA5, 1'b0, -1, 8'h00, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/range_report_tx.md
# range_report_tx

Downstream stage of the range finder: captures each completed `range`/`error` result on a one-cycle strobe and transmits it off-chip as a two-byte 8N1 UART frame on a single pin. It sits between the range finder outputs and a spare `uio_out` bit in the top-level wrapper. It lets a host read results without sampling `uo_out` in parallel.

## Interface
Parameters:
- `WIDTH`, default 8: width of `range`; legal range 1..8; zero-extended to 8 bits on transmit.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; minimum 2.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `range`  input  WIDTH  result from the range finder; sampled only on accept.
- `error`  input  1  error flag from the range finder; sampled only on accept.
- `result_valid`  input  1  one-cycle strobe: `range`/`error` are final this cycle.
- `tx`  output  1  UART line, idle high.
- `busy`  output  1  frame in progress; registered.
- `overrun`  output  1  sticky: a `result_valid` arrived while `busy`.

## Operation
- Accept rule: `result_valid && !busy` captures `{error, range}` into holding registers and starts a frame.
- Frame: byte 0 is the header, byte 1 is the range.
  - Header is 8'h52 when captured `error`=0 and 8'h45 when `error`=1.
  - Range byte is the captured `range`, zero-extended to 8 bits.
- Each byte is sent as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
- There is no gap between byte 0's stop bit and byte 1's start bit.
- FSM states:
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if byte index = 0 (index increments to 1).
  - STOP → IDLE if byte index = 1.
- Counters:
  - Bit-time counter `$clog2(CLKS_PER_BIT)` bits, wraps at CLKS_PER_BIT-1.
  - Bit index 3 bits.
  - Byte index 1 bit.
- Drop rule: `result_valid` while `busy` is ignored. Holding registers are unchanged, the current frame is unaffected, and `overrun` is set. `overrun` clears only on reset.
- Reset (any time, including mid-frame):
  - `tx`=1, `busy`=0, `overrun`=0, FSM=IDLE.
  - All counters and holding registers are cleared.
  - The partial frame is abandoned, with no completion.

## Timing
- Accept at edge n (strobe sampled high at edge n): `busy`=1 and `tx`=0 (start bit) from edge n on.
- Each bit holds exactly CLKS_PER_BIT cycles.
- A full frame is 20×CLKS_PER_BIT cycles.
- `busy` falls at edge n+20×CLKS_PER_BIT, which is also where the last stop bit ends.
- A `result_valid` in the last stop-bit cycle sees `busy`=1, so it is dropped and sets `overrun`.
- The earliest re-accept is the cycle in which `busy` reads 0.
- `tx` is registered and glitch-free; it changes only on bit boundaries.
- No combinational path from inputs to any output.

## Structure
- Package `range_report_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `HDR_OK`=8'h52 and `HDR_ERR`=8'h45.
- Sub-module `uart_byte_tx` (parameter CLKS_PER_BIT):
  - Inputs: `clk`, `rst_n`, `start`, `data[7:0]`.
  - Outputs: `tx`, `done` (1-cycle pulse at the end of the stop bit).
- Top `range_report_tx` owns:
  - capture, byte sequencing and the overrun flag;
  - `start` for byte 1, issued on byte 0's `done` (back-to-back), with the `done` timing adjusted so the line has no gap.

## Test plan
All scenarios use CLKS_PER_BIT=4, WIDTH=8.
- Reset check: hold `rst_n`=0 → `tx`=1, `busy`=0, `overrun`=0. Release → no change for 100 cycles.
- Normal frame: strobe with `range`=8'h3C, `error`=0.
  - Decoded bytes are 8'h52 then 8'h3C.
  - `busy` is high for exactly 80 cycles; each bit lasts 4 cycles.
- Error frame: strobe with `range`=8'h00, `error`=1 → bytes 8'h45 then 8'h00.
- Overrun: strobe 8'h11, then a second strobe with 8'h22 at cycle +10.
  - Output bytes are 8'h52, 8'h11 only; `overrun`=1 and stays 1.
  - A third strobe after `busy` falls transmits normally.
- Narrow width: WIDTH=5, `range`=5'h1F → range byte is 8'h1F, upper bits 0.
- Mid-frame reset: assert `rst_n`=0 during bit 3 of byte 1.
  - `tx`=1 and `busy`=0 immediately (asynchronously).
  - After release, a new strobe with 8'hA5 produces a clean 2-byte frame.
